io_cfg_loader: RTL and testbench

IO_CFG_LOADER -- requirements
Module: io_cfg_loader

---
 rtl/io_cfg_loader.sv | 183 ++++++++++++++++++
 tb/tb_io_cfg_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_cfg_loader.sv
// Framed byte-stream loader for per-IO TSMUX/DORREG configuration with atomic commit.
// Optional CRC-8 trailer check is enabled by defining CFG_CRC_EN.
module io_cfg_loader #(
  parameter int NIO = 8
) (
  input  logic             IOCLK,
  input  logic             RST,
  input  logic [7:0]       DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic [2*NIO-1:0] CFG_TSMUX,
  output logic [NIO-1:0]   CFG_DORREG,
  output logic             CFG_VALID,
  output logic             DONE,
  output logic             ERR
);

  localparam int         CW   = $clog2(NIO + 1);
  localparam logic [7:0] SYNC = 8'hA5;

`ifdef CFG_CRC_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [2*NIO-1:0] shadow_tsmux_reg;
  logic [NIO-1:0]   shadow_dorreg_reg;
  logic [2*NIO-1:0] tsmux_reg;
  logic [NIO-1:0]   dorreg_reg;
  logic             valid_reg;
  logic             done_reg;
  logic             err_reg;

  logic accept;
  logic byte_bad;
  logic last_payload;
  logic sync_hit;
  logic load_byte;
  logic frame_abort;
  logic commit;

  // Reset holds DREADY low combinationally so no byte is ever accepted under reset.
  assign DREADY       = !RST && (state_reg != COMMIT);
  assign accept       = DVALID && DREADY;
  assign byte_bad     = |DIN[7:3];
  assign last_payload = (cnt_reg == CW'(NIO - 1));

`ifdef CFG_CRC_EN
  logic [7:0] crc_reg;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge IOCLK) begin
    if (RST || sync_hit) begin
      crc_reg <= 8'h00;
    end else if (load_byte) begin
      crc_reg <= crc8_step(crc_reg, DIN);
    end
  end
`endif

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sync_hit    = 1'b0;
    load_byte   = 1'b0;
    frame_abort = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && DIN == SYNC) begin
          sync_hit   = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (byte_bad) begin
            frame_abort = 1'b1;
            state_next  = IDLE;
          end else begin
            load_byte = 1'b1;
            if (last_payload) begin
`ifdef CFG_CRC_EN
              state_next = CHECK;
`else
              state_next = COMMIT;
`endif
            end
          end
        end
      end
`ifdef CFG_CRC_EN
      CHECK: begin
        if (accept) begin
          if (DIN == crc_reg) begin
            state_next = COMMIT;
          end else begin
            frame_abort = 1'b1;
            state_next  = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge IOCLK) begin
    if (RST || sync_hit) begin
      cnt_reg <= '0;
    end else if (load_byte) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge IOCLK) begin
    if (RST || sync_hit) begin
      err_reg <= 1'b0;
    end else if (frame_abort) begin
      err_reg <= 1'b1;
    end
  end

  // Each IO slot owns its own shadow field; an aborted frame wipes the whole shadow.
  generate
    for (genvar gi = 0; gi < NIO; gi++) begin : g_shadow
      always_ff @(posedge IOCLK) begin
        if (RST || frame_abort) begin
          shadow_tsmux_reg[2*gi +: 2] <= 2'b00;
          shadow_dorreg_reg[gi]       <= 1'b0;
        end else if (load_byte && cnt_reg == CW'(gi)) begin
          shadow_tsmux_reg[2*gi +: 2] <= DIN[1:0];
          shadow_dorreg_reg[gi]       <= DIN[2];
        end
      end
    end
  endgenerate

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      tsmux_reg  <= '0;
      dorreg_reg <= '0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= commit;
      if (commit) begin
        tsmux_reg  <= shadow_tsmux_reg;
        dorreg_reg <= shadow_dorreg_reg;
        valid_reg  <= 1'b1;
      end
    end
  end

  assign CFG_TSMUX  = tsmux_reg;
  assign CFG_DORREG = dorreg_reg;
  assign CFG_VALID  = valid_reg;
  assign DONE       = done_reg;
  assign ERR        = err_reg;

endmodule

// File: tb/tb_io_cfg_loader.sv
// Randomized bench for io_cfg_loader (NIO=4) against a whole-stream frame parser model.
module tb_io_cfg_loader;

  localparam int         NIO  = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic             IOCLK;
  logic             RST;
  logic [7:0]       DIN;
  logic             DVALID;
  logic             DREADY;
  logic [2*NIO-1:0] CFG_TSMUX;
  logic [NIO-1:0]   CFG_DORREG;
  logic             CFG_VALID;
  logic             DONE;
  logic             ERR;

  io_cfg_loader #(.NIO(NIO)) dut (
    .IOCLK(IOCLK), .RST(RST), .DIN(DIN), .DVALID(DVALID), .DREADY(DREADY),
    .CFG_TSMUX(CFG_TSMUX), .CFG_DORREG(CFG_DORREG), .CFG_VALID(CFG_VALID),
    .DONE(DONE), .ERR(ERR)
  );

  initial IOCLK = 1'b0;
  always #5 IOCLK = ~IOCLK;

  int checks   = 0;
  int failures = 0;

  logic [7:0]       hist[$];
  logic [7:0]       stim[$];
  logic [2*NIO-1:0] m_ts;
  logic [NIO-1:0]   m_dr;
  logic             m_valid, m_err, m_last_commit;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

`ifdef CFG_CRC_EN
  // Bit-serial CRC-8 (poly x^8+x^2+x+1), MSB first, init 0.
  function automatic logic [7:0] crc_of(input logic [7:0] p[NIO]);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int j = 0; j < NIO; j++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ p[j][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction
`endif

  // Re-parses every byte accepted since reset and derives the expected outputs.
  task automatic parse_model();
    int         i, k, n, cend;
    logic       bad;
    logic [7:0] b;
    logic [7:0] pay[NIO];
    n = hist.size();
    m_ts = '0; m_dr = '0; m_valid = 1'b0; m_err = 1'b0;
    cend = -1; i = 0;
    while (i < n) begin
      if (hist[i] != SYNC) begin i++; continue; end
      m_err = 1'b0; i++; k = 0; bad = 1'b0;
      while (k < NIO && i < n) begin
        b = hist[i];
        if (b[7:3] != 5'd0) begin bad = 1'b1; i++; break; end
        pay[k] = b; k++; i++;
      end
      if (bad) begin m_err = 1'b1; continue; end
      if (k < NIO) break;
`ifdef CFG_CRC_EN
      if (i >= n) break;
      if (hist[i] != crc_of(pay)) begin m_err = 1'b1; i++; continue; end
      i++;
`endif
      for (int j = 0; j < NIO; j++) begin
        m_ts[2*j +: 2] = pay[j][1:0];
        m_dr[j]        = pay[j][2];
      end
      m_valid = 1'b1;
      cend    = i;
    end
    m_last_commit = (cend == n);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int               n;
    logic [2*NIO-1:0] prev_ts;
    logic [NIO-1:0]   prev_dr;
    repeat (gap) begin DVALID = 1'b0; @(posedge IOCLK); #1; end
    DIN = b; DVALID = 1'b1; n = 0;
    while (!DREADY && n < 20) begin @(posedge IOCLK); #1; n++; end
    if (!DREADY) begin
      check_eq("dready_timeout", 0, 1);
      DVALID = 1'b0;
      return;
    end
    prev_ts = m_ts; prev_dr = m_dr;
    @(posedge IOCLK); #1;
    DVALID = 1'b0;
    hist.push_back(b);
    parse_model();
    if (m_last_commit) begin
      check_eq("commit_dready", DREADY, 0);
      check_eq("done_early", DONE, 0);
      check_eq("cfg_early", {CFG_TSMUX, CFG_DORREG}, {prev_ts, prev_dr});
      @(posedge IOCLK); #1;
      check_eq("done_pulse", DONE, 1);
      check_eq("cfg_commit", {CFG_TSMUX, CFG_DORREG}, {m_ts, m_dr});
      check_eq("valid_commit", CFG_VALID, 1);
      check_eq("err_commit", ERR, m_err);
      @(posedge IOCLK); #1;
      check_eq("done_clear", DONE, 0);
    end else begin
      check_eq("cfg_hold", {CFG_TSMUX, CFG_DORREG}, {m_ts, m_dr});
      check_eq("done_idle", DONE, 0);
      check_eq("err", ERR, m_err);
      check_eq("valid", CFG_VALID, m_valid);
    end
  endtask

  task automatic do_reset();
    DVALID = 1'b0; RST = 1'b1;
    repeat (2) @(posedge IOCLK);
    #1;
    check_eq("rst_dready", DREADY, 0);
    check_eq("rst_cfg", {CFG_TSMUX, CFG_DORREG}, 0);
    check_eq("rst_valid", CFG_VALID, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_err", ERR, 0);
    RST = 1'b0;
    hist.delete();
    parse_model();
    @(posedge IOCLK); #1;
    check_eq("post_rst_dready", DREADY, 1);
    check_eq("post_rst_cfg", {CFG_TSMUX, CFG_DORREG, CFG_VALID, ERR}, 0);
  endtask

  task automatic add_frame(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] crc_xor);
    logic [7:0] pay[NIO];
    pay[0] = p0; pay[1] = p1; pay[2] = p2; pay[3] = p3;
    stim.push_back(SYNC);
    for (int j = 0; j < NIO; j++) stim.push_back(pay[j]);
`ifdef CFG_CRC_EN
    stim.push_back(crc_of(pay) ^ crc_xor);
`else
    if (crc_xor != 8'h00) stim.push_back(8'h00);
`endif
  endtask

  task automatic run_stim(input int gap_mode);
    int g;
    for (int i = 0; i < stim.size(); i++) begin
      g = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
      send_byte(stim[i], g);
    end
    stim.delete();
  endtask

  function automatic logic [7:0] rand_payload();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 7));
  endfunction

  initial begin
    DIN = 8'h00; DVALID = 1'b0; RST = 1'b1;
    do_reset();

    add_frame(8'h01, 8'h06, 8'h03, 8'h00, 8'h00);
    run_stim(0);
    check_eq("basic_tsmux", CFG_TSMUX, 8'b00_11_10_01);
    check_eq("basic_dorreg", CFG_DORREG, 4'b0010);
    check_eq("basic_err", ERR, 0);

    stim.push_back(8'h00); stim.push_back(8'hFF);
    add_frame(8'h02, 8'h04, 8'h01, 8'h07, 8'h00);
    run_stim(0);
    check_eq("lead_garbage_valid", CFG_VALID, 1);

    add_frame(8'h03, 8'h03, 8'h09, 8'h03, 8'h00);
    run_stim(0);
    check_eq("bad_rsvd_err", ERR, 1);
    add_frame(8'h05, 8'h02, 8'h06, 8'h01, 8'h00);
    run_stim(0);
    check_eq("recover_err", ERR, 0);

`ifdef CFG_CRC_EN
    add_frame(8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    run_stim(0);
    check_eq("crc_bad_err", ERR, 1);
`endif

    add_frame(8'h01, 8'h06, 8'h03, 8'h00, 8'h00);
    run_stim(1);
    check_eq("stall_tsmux", CFG_TSMUX, 8'b00_11_10_01);

    stim.push_back(SYNC); stim.push_back(8'h07); stim.push_back(8'h07);
    run_stim(0);
    do_reset();
    add_frame(8'h04, 8'h05, 8'h06, 8'h07, 8'h00);
    run_stim(0);
    check_eq("after_rst_dorreg", CFG_DORREG, 4'b1111);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) stim.push_back(8'($urandom_range(0, 255)));
      add_frame(rand_payload(), rand_payload(), rand_payload(), rand_payload(),
                ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
      run_stim(-1);
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
